// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md5_pkg
// Purpose  : Definitions shared by the candidate generator, the MD5 encrypter
//            and the hash comparator.
//            - Character-set radix.
//            - Sequencer state encoding.
//            - Digit-to-ASCII map.
//            - 128-bit message word type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package md5_pkg;

  // Radix of one candidate character: 0-9, A-Z, a-z.
  localparam int CHARSET_SIZE = 62;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left-justified message word as consumed by the encrypter.
  typedef logic [127:0] md5_word_t;

  // Map a digit value to its ASCII character.
  // Mapping:
  //   0..9   -> '0'..'9'
  //   10..35 -> 'A'..'Z'
  //   36..61 -> 'a'..'z'
  function automatic logic [7:0] digit_to_ascii(input logic [5:0] d);
    logic [7:0] w_d;
    w_d = {2'b00, d};
    if (d < 6'd10) begin
      return w_d + 8'h30;
    end else if (d < 6'd36) begin
      return w_d + 8'h37;
    end else begin
      return w_d + 8'h3D;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/guess_sequencer_charset_digit.sv
`default_nettype none
// ============================================================================
// Module   : charset_digit
// Purpose  : One odometer position of the candidate generator.
//            - When enabled, adds i_addend to the digit modulo the charset size.
//            - Reports a carry when the sum wraps.
//            - Emits the ASCII character of the resulting digit.
// Ports    : i_digit  [5:0] current digit value
//            i_addend [2:0] amount to add (stride or incoming carry)
//            i_enable       position is active and stepping this cycle
//            o_next   [5:0] digit value after the step (i_digit when disabled)
//            o_carry        sum wrapped past the last character
//            o_ascii  [7:0] ASCII character of o_next
// Revision : 1.0 - initial release
// ============================================================================
module charset_digit
  import md5_pkg::*;
(
  input  logic [5:0] i_digit,
  input  logic [2:0] i_addend,
  input  logic       i_enable,
  output logic [5:0] o_next,
  output logic       o_carry,
  output logic [7:0] o_ascii
);

  logic [6:0] w_sum;

  assign w_sum = {1'b0, i_digit} + {4'b0000, i_addend};

  // Digit plus addend never exceeds 61+7, so one subtraction is enough.
  always_comb begin
    o_next  = i_digit;
    o_carry = 1'b0;
    if (i_enable) begin
      if (w_sum >= 7'(CHARSET_SIZE)) begin
        o_next  = 6'(w_sum - 7'(CHARSET_SIZE));
        o_carry = 1'b1;
      end else begin
        o_next  = w_sum[5:0];
      end
    end
  end

  assign o_ascii = digit_to_ascii(o_next);

endmodule
`default_nettype wire

// File: rtl/guess_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : guess_sequencer
// Purpose  : Enumerates fixed-charset candidate passwords of growing length as
//            an odometer.
//            - Starts at a programmable digit offset.
//            - Steps with a programmable stride.
//            - Presents each candidate on a valid/ready handshake as a
//              left-justified 128-bit word plus its bit length.
// Ports    : clock              rising-edge clock
//            reset              asynchronous active-high reset
//            start              one-cycle start pulse (honoured in IDLE/DONE)
//            halt               level; forces IDLE
//            start_index [7:0]  initial digit 0 value, reduced mod 62
//            stride      [2:0]  per-transfer step of digit 0 (0 acts as 1)
//            guess_valid        candidate is valid
//            guess_ready        encrypter accepts the candidate
//            guess     [127:0]  candidate, first character in [127:120]
//            guess_len   [7:0]  candidate length in bits
//            busy               running
//            exhausted          search space finished
//            guess_count[31:0]  accepted transfers since start (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module guess_sequencer
  import md5_pkg::*;
#(
  parameter int MAX_LEN      = 8,
  parameter int CHARSET_SIZE = 62
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         halt,
  input  logic [7:0]   start_index,
  input  logic [2:0]   stride,
  output logic         guess_valid,
  input  logic         guess_ready,
  output logic [127:0] guess,
  output logic [7:0]   guess_len,
  output logic         busy,
  output logic         exhausted,
  output logic [31:0]  guess_count
);

  // Reduce an 8-bit value modulo the radix; 255 needs at most four subtractions.
  function automatic logic [5:0] reduce_start(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      if (r >= 8'(CHARSET_SIZE)) begin
        r = r - 8'(CHARSET_SIZE);
      end
    end
    return r[5:0];
  endfunction

  state_t       r_state;
  state_t       w_state_next;
  logic [5:0]   r_digit [MAX_LEN];
  logic [4:0]   r_len;
  md5_word_t    r_guess;
  logic [7:0]   r_guess_len;
  logic [31:0]  r_count;

  logic         w_in_run;
  logic         w_step;
  logic         w_load;
  logic         w_commit;
  logic         w_exhaust;
  logic         w_top_carry;
  logic [2:0]   w_stride;
  logic [5:0]   w_start_digit;
  logic [4:0]   w_len_next;
  logic [5:0]   w_digit_in   [MAX_LEN];
  logic [5:0]   w_digit_next [MAX_LEN];
  logic [2:0]   w_addend     [MAX_LEN];
  logic [7:0]   w_ascii      [MAX_LEN];
  logic [MAX_LEN-1:0] w_carry;
  md5_word_t    w_right;
  md5_word_t    w_pack;
  logic [7:0]   w_shift;

  assign w_in_run      = (r_state == RUN);
  assign w_step        = w_in_run && guess_ready;
  assign w_stride      = (stride == 3'd0) ? 3'd1 : stride;
  assign w_start_digit = reduce_start(start_index);

  // Outside RUN the digit chain is fed the reload values with stepping
  // disabled, so its outputs are directly the first candidate after a start.
  // Keeping this select on the registered state avoids a loop through the FSM.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign w_digit_in[i] = w_in_run ? r_digit[i] : w_start_digit;
      assign w_addend[i]   = w_stride;
    end else begin : g_upper
      assign w_digit_in[i] = w_in_run ? r_digit[i] : 6'd0;
      assign w_addend[i]   = {2'b00, w_carry[i-1]};
    end

    charset_digit u_digit (
      .i_digit  (w_digit_in[i]),
      .i_addend (w_addend[i]),
      .i_enable (w_step && (5'(i) < r_len)),
      .o_next   (w_digit_next[i]),
      .o_carry  (w_carry[i]),
      .o_ascii  (w_ascii[i])
    );
  end

  // Carry out of the current most significant digit.
  always_comb begin
    w_top_carry = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (r_len == 5'(i + 1)) begin
        w_top_carry = w_carry[i];
      end
    end
  end

  // The top position only steps once the candidate is MAX_LEN long.
  assign w_exhaust = w_carry[MAX_LEN-1];

  // On growth the new top digit is already 0: positions above the current
  // length are never stepped and are cleared on every reload.
  always_comb begin
    w_len_next = r_len;
    if (!w_in_run) begin
      w_len_next = 5'd1;
    end else if (w_top_carry && (r_len < 5'(MAX_LEN))) begin
      w_len_next = r_len + 5'd1;
    end
  end

  // Build right-justified, then shift so the first character lands in [127:120].
  always_comb begin
    w_right = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < w_len_next) begin
        w_right[8*i +: 8] = w_ascii[i];
      end
    end
  end

  assign w_shift = {5'd16 - w_len_next, 3'b000};
  assign w_pack  = w_right << w_shift;

  // Next-state logic; halt takes priority over start and over exhaustion.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (guess_ready) begin
          if (w_exhaust) begin
            w_state_next = DONE;
          end else begin
            w_commit = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (halt) begin
      w_state_next = IDLE;
      w_load       = 1'b0;
      w_commit     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= 5'd1;
      r_guess     <= '0;
      r_guess_len <= '0;
      r_count     <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_digit[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_load || w_commit) begin
        r_len       <= w_len_next;
        r_guess     <= w_pack;
        r_guess_len <= {w_len_next, 3'b000};
        for (int i = 0; i < MAX_LEN; i++) begin
          r_digit[i] <= w_digit_next[i];
        end
      end
      // A transfer in the halt cycle or the exhausting cycle still counts.
      if (w_load) begin
        r_count <= '0;
      end else if (w_step && (r_count != 32'hFFFF_FFFF)) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign guess_valid = w_in_run;
  assign busy        = w_in_run;
  assign exhausted   = (r_state == DONE);
  assign guess       = r_guess;
  assign guess_len   = r_guess_len;
  assign guess_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_guess_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_guess_sequencer
// Purpose  : Directed self-checking bench for guess_sequencer.
//            - Default instance with MAX_LEN = 8.
//            - Short instance with MAX_LEN = 2 for the exhaustion case.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         halt = 1'b0;
  logic [7:0]   start_index = 8'd0;
  logic [2:0]   stride = 3'd0;
  logic         guess_ready = 1'b0;

  logic         valid_a, busy_a, exh_a;
  logic [127:0] guess_a;
  logic [7:0]   len_a;
  logic [31:0]  count_a;

  logic         valid_b, busy_b, exh_b;
  logic [127:0] guess_b;
  logic [7:0]   len_b;
  logic [31:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  guess_sequencer #(.MAX_LEN(8)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .start_index (start_index),
    .stride      (stride),
    .guess_valid (valid_a),
    .guess_ready (guess_ready),
    .guess       (guess_a),
    .guess_len   (len_a),
    .busy        (busy_a),
    .exhausted   (exh_a),
    .guess_count (count_a)
  );

  guess_sequencer #(.MAX_LEN(2)) u_dut_short (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .start_index (start_index),
    .stride      (stride),
    .guess_valid (valid_b),
    .guess_ready (guess_ready),
    .guess       (guess_b),
    .guess_len   (len_b),
    .busy        (busy_b),
    .exhausted   (exh_b),
    .guess_count (count_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Charset map written from the character table.
  function automatic logic [7:0] ch(input int k);
    if (k < 10) return 8'(8'h30 + k);
    else if (k < 36) return 8'(8'h41 + (k - 10));
    else return 8'(8'h61 + (k - 36));
  endfunction

  function automatic logic [127:0] w1(input logic [7:0] c);
    return {c, 120'd0};
  endfunction

  function automatic logic [127:0] w2(input logic [7:0] a, input logic [7:0] b);
    return {a, b, 112'd0};
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic halt_pulse();
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
  endtask

  initial begin
    int           n;
    logic [127:0] last;
    logic [7:0]   last_len;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clock);
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_exh", exh_a, 1'b0);
    check("rst_guess", guess_a, 128'd0);
    check("rst_len", len_a, 8'd0);
    check("rst_count", count_a, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_valid", valid_a, 1'b0);

    // ---------------- index 0, stride 1: single chars then "00" ----------------
    start_index = 8'd0;
    stride      = 3'd1;
    guess_ready = 1'b1;
    start_pulse();
    check("a_busy", busy_a, 1'b1);
    for (int k = 0; k < 62; k++) begin
      check($sformatf("a_char%0d", k), guess_a, w1(ch(k)));
      check($sformatf("a_len%0d", k), len_a, 8'd8);
      @(negedge clock);
    end
    check("a_z_was_last", w1(ch(61)), 128'h7A << 120);
    check("a_00", guess_a, 128'h3030 << 112);
    check("a_00_len", len_a, 8'd16);
    check("a_count62", count_a, 32'd62);
    @(negedge clock);
    check("a_count63", count_a, 32'd63);
    check("a_01", guess_a, w2(8'h30, 8'h31));

    // halt during RUN, with a transfer in the same cycle
    halt_pulse();
    check("halt_valid", valid_a, 1'b0);
    check("halt_busy", busy_a, 1'b0);
    check("halt_guess_hold", guess_a, w2(8'h30, 8'h31));
    check("halt_len_hold", len_a, 8'd16);
    check("halt_count", count_a, 32'd64);

    // ---------------- index 200, stride 0 ----------------
    start_index = 8'd200;
    stride      = 3'd0;
    start_pulse();
    check("b_E", guess_a, w1(8'h45));
    // start while running must be ignored
    start_index = 8'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("b_F", guess_a, w1(8'h46));
    check("b_count", count_a, 32'd1);
    halt_pulse();

    // ---------------- index 60, stride 3 ----------------
    start_index = 8'd60;
    stride      = 3'd3;
    start_pulse();
    check("c_y", guess_a, w1(8'h79));
    @(negedge clock);
    check("c_01", guess_a, w2(8'h30, 8'h31));
    check("c_01_len", len_a, 8'd16);
    @(negedge clock);
    check("c_04", guess_a, w2(8'h30, 8'h34));
    halt_pulse();

    // ---------------- backpressure ----------------
    start_index = 8'd7;
    stride      = 3'd1;
    guess_ready = 1'b0;
    start_pulse();
    check("bp_first", guess_a, w1(8'h37));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("bp_hold%0d", k), guess_a, w1(8'h37));
      check($sformatf("bp_cnt%0d", k), count_a, 32'd0);
      check($sformatf("bp_valid%0d", k), valid_a, 1'b1);
    end
    guess_ready = 1'b1;
    @(negedge clock);
    check("bp_next8", guess_a, w1(8'h38));
    check("bp_count1", count_a, 32'd1);
    halt_pulse();

    // ---------------- start and halt together ----------------
    start = 1'b1;
    halt  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    halt  = 1'b0;
    check("sh_busy", busy_a, 1'b0);
    check("sh_valid", valid_a, 1'b0);
    @(negedge clock);
    check("sh_still_idle", busy_a, 1'b0);

    // ---------------- MAX_LEN = 2 exhaustion ----------------
    start_index = 8'd0;
    stride      = 3'd1;
    guess_ready = 1'b1;
    start_pulse();
    n        = 0;
    last     = '0;
    last_len = '0;
    for (int c = 0; c < 5000; c++) begin
      if (!valid_b) break;
      last     = guess_b;
      last_len = len_b;
      n++;
      @(negedge clock);
    end
    check("ex_transfers", 128'(n), 128'd3906);
    check("ex_last_zz", last, w2(8'h7A, 8'h7A));
    check("ex_last_len", last_len, 8'd16);
    check("ex_valid", valid_b, 1'b0);
    check("ex_exhausted", exh_b, 1'b1);
    check("ex_count", count_b, 32'd3906);
    @(negedge clock);
    check("ex_no_repeat", valid_b, 1'b0);
    start_pulse();
    check("ex_restart_0", guess_b, w1(8'h30));
    check("ex_restart_len", len_b, 8'd8);
    check("ex_restart_cnt", count_b, 32'd0);
    check("ex_restart_exh", exh_b, 1'b0);

    // ---------------- asynchronous reset mid-RUN ----------------
    @(negedge clock);
    check("ar_running", busy_b, 1'b1);
    reset = 1'b1;
    #1;
    check("ar_valid", valid_b, 1'b0);
    check("ar_busy", busy_b, 1'b0);
    check("ar_guess", guess_b, 128'd0);
    check("ar_len", len_b, 8'd0);
    check("ar_count", count_b, 32'd0);
    check("ar_busy_a", busy_a, 1'b0);
    check("ar_guess_a", guess_a, 128'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ar_stay_idle", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
